mem_result_unloader: RTL and testbench

- Reader-side counterpart of the banked coefficient memory preload: after the NTT core asserts done, streams the whole polynomial out of memory_rtl in natural coefficient order.
- Addressing rule: coefficient i = k*BN + b lives at bank b, row k.
- Output is one coefficient per cycle over a valid/ready stream, feeding the golden comparator or a host readback port.
- Double-buffers memory rows so the stream has no bubbles while out_ready stays high.

---
 rtl/ntt_mem_pkg.sv | 18 +
 rtl/mem_result_unloader_if.sv | 29 ++
 rtl/mem_result_unloader_row_pingpong_buf.sv | 56 +++++
 rtl/mem_result_unloader.sv | 155 +++++++++++++++
 tb/tb_mem_result_unloader.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/ntt_mem_pkg.sv
// Shared parameters, coefficient/row types and unloader FSM states for the
// banked NTT coefficient memory.
package ntt_mem_pkg;

  localparam int D_WIDTH = 17;
  localparam int BN      = 16;
  localparam int MA      = 64;

  typedef logic [D_WIDTH-1:0] coef_t;
  typedef coef_t [BN-1:0]     row_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } unload_state_e;

endpackage

// File: rtl/mem_result_unloader_if.sv
// Row-read port towards memory_rtl plus the coefficient output stream.
interface mem_result_unloader_if #(
  parameter int D_WIDTH = ntt_mem_pkg::D_WIDTH,
  parameter int BN      = ntt_mem_pkg::BN,
  parameter int MA      = ntt_mem_pkg::MA
);
  localparam int ROW_W = (MA > 1) ? $clog2(MA) : 1;
  localparam int IDX_W = (BN * MA > 1) ? $clog2(BN * MA) : 1;

  logic                    rd_en;
  logic [ROW_W-1:0]        rd_row;
  logic [BN*D_WIDTH-1:0]   rd_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [D_WIDTH-1:0]      out_data;
  logic [IDX_W-1:0]        out_idx;
  logic                    out_last;

  modport master (
    output rd_en, rd_row, out_valid, out_data, out_idx, out_last,
    input  rd_data, out_ready
  );

  modport slave (
    input  rd_en, rd_row, out_valid, out_data, out_idx, out_last,
    output rd_data, out_ready
  );

endinterface

// File: rtl/mem_result_unloader_row_pingpong_buf.sv
// Two row buffers with full flags: one fills from memory while the other
// drains one word per handshake.
module row_pingpong_buf #(
  parameter int D_WIDTH = ntt_mem_pkg::D_WIDTH,
  parameter int BN      = ntt_mem_pkg::BN,
  parameter int B_W     = (BN > 1) ? $clog2(BN) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic                  wr_sel,
  input  logic [BN*D_WIDTH-1:0] wr_data,
  input  logic                  rd_sel,
  input  logic [B_W-1:0]        rd_b,
  input  logic                  free,
  output logic [1:0]            full,
  output logic [D_WIDTH-1:0]    rd_word
);

  logic [D_WIDTH-1:0] word_r [2][BN];
  logic [1:0]         full_r;

  // Row storage: a capture overwrites the whole target row at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        for (int j = 0; j < BN; j++) begin
          word_r[i][j] <= '0;
        end
      end
    end else if (wr_en) begin
      for (int j = 0; j < BN; j++) begin
        word_r[wr_sel][j] <= wr_data[j*D_WIDTH +: D_WIDTH];
      end
    end
  end

  // Full flags: set on capture, cleared when the last word of the row drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_r <= 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (wr_en && (wr_sel == 1'(i))) begin
          full_r[i] <= 1'b1;
        end else if (free && (rd_sel == 1'(i))) begin
          full_r[i] <= 1'b0;
        end
      end
    end
  end

  assign full    = full_r;
  assign rd_word = word_r[rd_sel][rd_b];

endmodule

// File: rtl/mem_result_unloader.sv
// Streams a finished polynomial out of the banked coefficient memory in
// natural order, double-buffering rows so the output never bubbles.
module mem_result_unloader #(
  parameter int D_WIDTH = ntt_mem_pkg::D_WIDTH,
  parameter int BN      = ntt_mem_pkg::BN,
  parameter int MA      = ntt_mem_pkg::MA
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  unload_done,
  mem_result_unloader_if.master bus
);

  localparam int ROW_W = (MA > 1) ? $clog2(MA) : 1;
  localparam int IDX_W = (BN * MA > 1) ? $clog2(BN * MA) : 1;
  localparam int B_W   = (BN > 1) ? $clog2(BN) : 1;
  localparam int NR_W  = ROW_W + 1;

  typedef ntt_mem_pkg::unload_state_e state_t;

  generate
    if (BN < 2) begin : g_bn_min
      $error("mem_result_unloader: BN must be at least 2");
    end
    if ((BN & (BN - 1)) != 0) begin : g_bn_pow2
      $error("mem_result_unloader: BN must be a power of two");
    end
  endgenerate

  state_t             state_r;
  state_t             state_s;
  logic [NR_W-1:0]    nr_r;
  logic [ROW_W-1:0]   row_r;
  logic [B_W-1:0]     b_r;
  logic               rd_pend_r;
  logic               cap_sel_r;
  logic [1:0]         full_s;
  logic               act_s;
  logic               tgt_s;
  logic               valid_s;
  logic               hs_s;
  logic               free_s;
  logic               last_s;
  logic               issue_s;
  logic [D_WIDTH-1:0] word_s;

  // Row k always lands in buffer k[0]; the drained row's LSB picks the active one.
  assign act_s   = row_r[0];
  assign tgt_s   = nr_r[0];
  assign valid_s = (state_r == ntt_mem_pkg::ST_RUN) && full_s[act_s];
  assign hs_s    = valid_s && bus.out_ready;
  assign free_s  = hs_s && (b_r == B_W'(BN - 1));
  assign last_s  = (row_r == ROW_W'(MA - 1)) && (b_r == B_W'(BN - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ntt_mem_pkg::ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state and row-read issue decision.
  always_comb begin
    state_s = state_r;
    issue_s = 1'b0;
    case (state_r)
      ntt_mem_pkg::ST_IDLE: begin
        if (start) begin
          state_s = ntt_mem_pkg::ST_RUN;
        end else begin
          state_s = ntt_mem_pkg::ST_IDLE;
        end
      end
      ntt_mem_pkg::ST_RUN: begin
        if ((nr_r < NR_W'(MA)) && !rd_pend_r &&
            (!full_s[tgt_s] || (free_s && (tgt_s == act_s)))) begin
          issue_s = 1'b1;
        end else begin
          issue_s = 1'b0;
        end
        if (hs_s && last_s) begin
          state_s = ntt_mem_pkg::ST_FLUSH;
        end else begin
          state_s = ntt_mem_pkg::ST_RUN;
        end
      end
      ntt_mem_pkg::ST_FLUSH: begin
        state_s = ntt_mem_pkg::ST_IDLE;
      end
      default: begin
        state_s = ntt_mem_pkg::ST_IDLE;
      end
    endcase
  end

  // Fetch and drain counters; all cleared when a new unload is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nr_r      <= '0;
      row_r     <= '0;
      b_r       <= '0;
      rd_pend_r <= 1'b0;
      cap_sel_r <= 1'b0;
    end else begin
      rd_pend_r <= issue_s;
      if (issue_s) begin
        nr_r      <= nr_r + NR_W'(1);
        cap_sel_r <= tgt_s;
      end
      if ((state_r == ntt_mem_pkg::ST_IDLE) && start) begin
        nr_r  <= '0;
        row_r <= '0;
        b_r   <= '0;
      end else if (hs_s) begin
        if (free_s) begin
          b_r   <= '0;
          row_r <= row_r + ROW_W'(1);
        end else begin
          b_r   <= b_r + B_W'(1);
        end
      end
    end
  end

  row_pingpong_buf #(
    .D_WIDTH (D_WIDTH),
    .BN      (BN),
    .B_W     (B_W)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (rd_pend_r),
    .wr_sel  (cap_sel_r),
    .wr_data (bus.rd_data),
    .rd_sel  (act_s),
    .rd_b    (b_r),
    .free    (free_s),
    .full    (full_s),
    .rd_word (word_s)
  );

  assign bus.rd_en     = issue_s;
  assign bus.rd_row    = nr_r[ROW_W-1:0];
  assign bus.out_valid = valid_s;
  assign bus.out_data  = word_s;
  assign bus.out_idx   = IDX_W'({row_r, b_r});
  assign bus.out_last  = valid_s && last_s;
  assign busy          = (state_r == ntt_mem_pkg::ST_RUN);
  assign unload_done   = (state_r == ntt_mem_pkg::ST_FLUSH);

endmodule

// File: tb/tb_mem_result_unloader.sv
// Directed bench for mem_result_unloader: BN=16/MA=4 stream scenarios plus an
// MA=1 instance; memory word (b,k) holds k*16+b (+5 for the MA=1 memory).
module tb_mem_result_unloader;

  localparam int DW = 17;
  localparam int BN = 16;
  localparam int MA = 4;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic start  = 1'b0;
  logic start1 = 1'b0;
  logic busy, unload_done, busy1, done1;

  int n_chk  = 0;
  int n_pass = 0;

  mem_result_unloader_if #(.D_WIDTH(DW), .BN(BN), .MA(MA)) bus ();
  mem_result_unloader_if #(.D_WIDTH(DW), .BN(BN), .MA(1))  bus1 ();

  mem_result_unloader #(.D_WIDTH(DW), .BN(BN), .MA(MA)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
    .unload_done(unload_done), .bus(bus)
  );

  mem_result_unloader #(.D_WIDTH(DW), .BN(BN), .MA(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1),
    .unload_done(done1), .bus(bus1)
  );

  always #5 clk = ~clk;

  // Memory models: registered row read, data valid one cycle after rd_en.
  always @(posedge clk) begin
    if (bus.rd_en) begin
      for (int b = 0; b < BN; b++) bus.rd_data[b*DW +: DW] <= DW'(int'(bus.rd_row) * BN + b);
    end
    if (bus1.rd_en) begin
      for (int b = 0; b < BN; b++) bus1.rd_data[b*DW +: DW] <= DW'(int'(bus1.rd_row) * BN + b + 5);
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Called at edge+1 of cycle T; returns at edge+1 of cycle T+1.
  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // mode 0: ready high, 1: random stalls, 2: ready low for 40 cycles.
  task automatic stream(input int mode, input int restart_idx);
    int exp = 0, nfetch = 0, c = 1, ahead = 0, max_ahead = 0;
    bit stall = 1'b0, done = 1'b0, ready = 1'b1, pulsed = 1'b0;
    while (!done && c <= 600) begin
      case (mode)
        1:       ready = ($urandom_range(0, 2) != 0);
        2:       ready = (c > 40);
        default: ready = 1'b1;
      endcase
      bus.out_ready = ready;
      start = (!pulsed && restart_idx >= 0 && exp == restart_idx);
      if (start) pulsed = 1'b1;
      #1;
      if (bus.rd_en) begin
        chk("rd_row", int'(bus.rd_row), nfetch);
        nfetch++;
      end
      if (c == 1) chk("busy_on", busy, 1);
      if (mode == 0) chk("valid_slot", bus.out_valid, int'(c >= 3 && c <= 66));
      if (stall) chk("valid_hold", bus.out_valid, 1);
      if (mode == 2 && c == 40) begin
        chk("stall_fetch", nfetch, 2);
        chk("stall_valid", bus.out_valid, 1);
        chk("stall_idx", int'(bus.out_idx), 0);
      end
      if (bus.out_valid) begin
        chk("data", int'(bus.out_data), exp);
        chk("idx", int'(bus.out_idx), exp);
        chk("last", bus.out_last, int'(exp == 63));
      end
      if (unload_done) begin
        done = 1'b1;
        chk("done_count", exp, 64);
        chk("busy_off", busy, 0);
        if (mode == 0) chk("done_cycle", c, 67);
      end
      stall = bus.out_valid && !ready;
      if (bus.out_valid && ready) exp++;
      ahead = nfetch - exp / BN;
      if (ahead > max_ahead) max_ahead = ahead;
      if (!done) begin
        @(posedge clk); #1;
        c++;
      end
    end
    start = 1'b0;
    chk("finished", int'(done), 1);
    chk("rd_count", nfetch, MA);
    chk("rows_ahead_le2", int'(max_ahead <= 2), 1);
  endtask

  initial begin
    bit hit, done;
    int n, nrd, bad;
    bus.out_ready  = 1'b1;
    bus1.out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_data", int'(bus.out_data), 0);
    chk("rst_idx", int'(bus.out_idx), 0);
    chk("rst_last", bus.out_last, 0);
    chk("rst_rd_en", bus.rd_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", unload_done, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Full-rate run with an ignored start at idx 20, then restart 2 cycles after done.
    do_start();
    stream(0, 20);
    @(posedge clk); #1;
    @(posedge clk); #1;
    do_start();
    stream(1, -1);
    @(posedge clk); #1;
    do_start();
    stream(2, -1);

    // Asynchronous reset in the middle of a run.
    @(posedge clk); #1;
    do_start();
    hit = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin
      bus.out_ready = 1'b1;
      #1;
      if (bus.out_valid && bus.out_idx == 6'd30) hit = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    chk("reached_idx30", int'(hit), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", bus.out_valid, 0);
    chk("arst_data", int'(bus.out_data), 0);
    chk("arst_idx", int'(bus.out_idx), 0);
    chk("arst_last", bus.out_last, 0);
    chk("arst_rd_en", bus.rd_en, 0);
    chk("arst_busy", busy, 0);
    #2;
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #2;
      if (bus.rd_en || bus.out_valid || busy) bad++;
    end
    chk("post_rst_quiet", bad, 0);
    @(posedge clk); #1;
    do_start();
    stream(0, -1);

    // Single-row memory instance.
    @(posedge clk); #1;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    n = 0;
    nrd = 0;
    done = 1'b0;
    for (int c = 1; c <= 60 && !done; c++) begin
      bus1.out_ready = 1'b1;
      #1;
      if (bus1.rd_en) nrd++;
      if (bus1.out_valid) begin
        chk("ma1_data", int'(bus1.out_data), n + 5);
        chk("ma1_idx", int'(bus1.out_idx), n);
        chk("ma1_last", bus1.out_last, int'(n == 15));
        n++;
      end
      if (done1) begin
        done = 1'b1;
        chk("ma1_done_cycle", c, 19);
      end
      @(posedge clk); #1;
    end
    chk("ma1_words", n, 16);
    chk("ma1_reads", nrd, 1);
    chk("ma1_finished", int'(done), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
